memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter MEM_LATENCY, default 5, service cycles per request (legal range 2..15).
REQ-002 Parameter FIFO_DEPTH, default 4, request queue entries (power of two).
REQ-003 Parameter MEM_LINES, default 256, cachelines of backing storage (power of two).
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_ren  input  1  read-line request valid.
REQ-007 req_wen  input  1  write-line request valid.
REQ-008 req_addr  input  pptr_t  physical address of line.
REQ-009 req_wdata  input  cacheline_t  write data.
REQ-010 req_ready  output  1  queue not full; a request is accepted at a posedge only when req_ready is high.
REQ-011 rec_en  output  1  one-cycle pulse: read response valid.
REQ-012 rec_addr  output  pptr_t  address echoed from the serviced read request.
REQ-013 rec_cacheline  output  cacheline_t  line data for rec_addr.

Function
REQ-014 Line index = req_addr bits [LINE_OFFSET_BITS +: log2(MEM_LINES)]; offset and upper bits are ignored for storage.
REQ-015 Accept: (req_ren|req_wen) & req_ready at posedge -> push {is_write, addr, wdata} into FIFO; when req_ready is low, requests are dropped, with no side effect.
REQ-016 req_ren & req_wen together: one entry, treated as a write; no read response.
REQ-017 req_ready = (count < FIFO_DEPTH), registered-count based; it is never deasserted combinationally by same-cycle inputs.
REQ-018 FSM states IDLE, BUSY, RESPOND. IDLE & FIFO non-empty -> pop head, load counter = MEM_LATENCY-1, go to BUSY.
REQ-019 BUSY: decrement counter each cycle; at counter==0, a write commits to the array and goes to IDLE, and a read latches the array line plus addr and goes to RESPOND.
REQ-020 RESPOND: rec_en=1 for exactly one cycle, then go to IDLE; the FSM can pop the next entry on the following edge.
REQ-021 Unloaded read latency: the accepting edge at cycle 0 gives rec_en high in cycle MEM_LATENCY+2 (enqueue, pop, MEM_LATENCY-1 counting, respond).
REQ-022 Responses are returned in strict acceptance order; writes are serviced in order, so a read after a write to the same line returns the written data.
REQ-023 Simultaneous push and pop in one cycle is legal; count is unchanged; wrap-around of read/write pointers is modulo FIFO_DEPTH.
REQ-024 rec_addr and rec_cacheline hold their last values while rec_en=0.
REQ-025 Backing array is not reset; contents are undefined until written.

Reset
REQ-026 rst=0 asynchronously forces: FSM=IDLE, count=0, pointers=0, counter=0, rec_en=0, rec_addr=0, rec_cacheline=0, req_ready=1 (after release).
REQ-027 Reset mid-operation discards all queued and in-service requests; no rec_en is produced for them, and an in-service write is not committed.
REQ-028 Array contents survive reset.

Structure
REQ-029 pptr_t, cacheline_t, LINE_OFFSET_BITS, and default MEM_LATENCY are defined in common.sv; the request-entry struct (is_write, addr, wdata) is also added to common.
REQ-030 One sub-module, req_fifo (parameterised depth/type, push/pop/full/empty/count); the FSM and array stay in memory_responder.

Verification
REQ-031 Write 0xAAAA... to addr 0x1040, then read 0x1040 -> one rec_en pulse, rec_addr=0x1040, rec_cacheline=0xAAAA..., read at MEM_LATENCY+2 cycles after read acceptance.
REQ-032 Issue 5 reads back-to-back with FIFO_DEPTH=4 and service stalled -> req_ready low after the 4th; the 5th is dropped; exactly 4 in-order responses, spaced MEM_LATENCY+2 cycles apart.
REQ-033 Assert req_ren & req_wen on 0x2000 with data 0x55... -> no rec_en; a later read of 0x2000 returns 0x55....
REQ-034 Assert rst=0 asynchronously mid-BUSY on a read -> rec_en is never pulsed for it, req_ready=1, and the next read completes normally with the prior array data intact.
REQ-035 Run 20 random reads/writes through pointer wrap, with a push and pop in the same cycle while full-1 -> responses match the reference model; count is never above FIFO_DEPTH.
REQ-036 Read 0x1040 and 0x1044 (same line) -> identical rec_cacheline; rec_addr echoes each exact address.

Source files
------------

// File: rtl/common.sv
// rtl/common.sv - shared address/line types and the queued memory request entry
package common;

    localparam int LINE_OFFSET_BITS    = 5;
    localparam int CACHELINE_BITS      = 8 << LINE_OFFSET_BITS;
    localparam int PPTR_BITS           = 32;
    localparam int DEFAULT_MEM_LATENCY = 5;

    typedef logic [PPTR_BITS-1:0]      pptr_t;
    typedef logic [CACHELINE_BITS-1:0] cacheline_t;

    typedef struct packed {
        logic       is_write;
        pptr_t      addr;
        cacheline_t wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } resp_state_t;

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - circular request queue with registered occupancy count
module req_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  T                           push_data_i,
    input  logic                       pop_i,
    output T                           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 slots_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = slots_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (do_push) slots_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - fixed-latency cacheline memory model with in-order read responses
module memory_responder
    import common::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int FIFO_DEPTH  = 4,
    parameter int MEM_LINES   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_ren,
    input  logic       req_wen,
    input  pptr_t      req_addr,
    input  cacheline_t req_wdata,
    output logic       req_ready,
    output logic       rec_en,
    output pptr_t      rec_addr,
    output cacheline_t rec_cacheline
);

    localparam int IDX_W   = $clog2(MEM_LINES);
    localparam int CNT_W   = 4;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

    function automatic logic [IDX_W-1:0] line_idx(input pptr_t a);
        return a[LINE_OFFSET_BITS +: IDX_W];
    endfunction

    resp_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          cur_q, cur_d;
    logic              rec_en_q, rec_en_d;
    pptr_t             rec_addr_q, rec_addr_d;
    cacheline_t        rec_line_q, rec_line_d;
    cacheline_t        mem_q [MEM_LINES];

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    mem_req_t          fifo_head, fifo_in;
    logic              mem_we;

    // A combined read+write request is queued as a plain write.
    assign fifo_in   = '{is_write: req_wen, addr: req_addr, wdata: req_wdata};
    assign req_ready = (fifo_count < FCNT_W'(FIFO_DEPTH));
    assign fifo_push = (req_ren | req_wen) & ~fifo_full;

    req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (mem_req_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        fifo_pop   = 1'b0;
        mem_we     = 1'b0;
        rec_en_d   = 1'b0;
        rec_addr_d = rec_addr_q;
        rec_line_d = rec_line_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_head;
                    cnt_d    = CNT_W'(MEM_LATENCY - 1);
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    if (cur_q.is_write) begin
                        mem_we  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // Reuse the wdata slot to hold the fetched line until it is presented.
                        cur_d.wdata = mem_q[line_idx(cur_q.addr)];
                        state_d     = ST_RESPOND;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                rec_en_d   = 1'b1;
                rec_addr_d = cur_q.addr;
                rec_line_d = cur_q.wdata;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            rec_en_q   <= 1'b0;
            rec_addr_q <= '0;
            rec_line_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            rec_en_q   <= rec_en_d;
            rec_addr_q <= rec_addr_d;
            rec_line_q <= rec_line_d;
        end
    end

    // Backing store is deliberately outside the reset domain so it survives rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[line_idx(cur_q.addr)] <= cur_q.wdata;
    end

    assign rec_en        = rec_en_q;
    assign rec_addr      = rec_addr_q;
    assign rec_cacheline = rec_line_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - randomized and directed bench for memory_responder against a timing/data model
module tb_memory_responder;
    import common::*;

    localparam int L = 5;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_ren, req_wen;
    pptr_t      req_addr;
    cacheline_t req_wdata;
    logic       req_ready, rec_en;
    pptr_t      rec_addr;
    cacheline_t rec_cacheline;

    memory_responder #(.MEM_LATENCY(L), .FIFO_DEPTH(D), .MEM_LINES(256)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_ren       (req_ren),
        .req_wen       (req_wen),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rec_en        (rec_en),
        .rec_addr      (rec_addr),
        .rec_cacheline (rec_cacheline)
    );

    always #5 clk = ~clk;

    typedef struct {
        pptr_t      addr;
        cacheline_t data;
        int         edge_no;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    int         pend_pop[$];
    int         server_free = 0;
    cacheline_t model_mem [256];
    bit         model_valid [256];
    pptr_t      last_addr;
    cacheline_t last_line;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input pptr_t a);
        return int'((a >> LINE_OFFSET_BITS) & 32'hFF);
    endfunction

    // Occupancy after edge cyc: accepted entries whose service has not yet started.
    task automatic model_count(output int c);
        while (pend_pop.size() > 0 && pend_pop[0] <= cyc) void'(pend_pop.pop_front());
        c = pend_pop.size();
    endtask

    // Called just after a negedge; presents one request across the next posedge.
    task automatic drive(input bit r, input bit w, input pptr_t a, input cacheline_t d);
        int c;
        int pop_t;
        bit exp_rdy;
        req_ren   = r;
        req_wen   = w;
        req_addr  = a;
        req_wdata = d;
        model_count(c);
        exp_rdy = (c < D);
        chk("req_ready", req_ready, exp_rdy);
        chk("fifo_count_bound", dut.u_fifo.count_o <= D, 1);
        if ((r || w) && exp_rdy) begin
            pop_t       = (cyc + 2 > server_free) ? cyc + 2 : server_free;
            server_free = pop_t + (w ? L + 1 : L + 2);
            pend_pop.push_back(pop_t);
            if (w) begin
                model_mem[idx_of(a)]   = d;
                model_valid[idx_of(a)] = 1'b1;
            end else begin
                exp_q.push_back('{addr: a, data: model_mem[idx_of(a)], edge_no: pop_t + L + 1});
            end
        end
        @(posedge clk);
        @(negedge clk);
        req_ren = 1'b0;
        req_wen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() > 0 || cyc < server_free + 1) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_within_budget", guard < 300, 1);
    endtask

    // Every cycle: rec_en must pulse exactly at the predicted edge and nowhere else.
    always @(negedge clk) begin
        bit due;
        exp_t e;
        if (rst !== 1'bx) begin
            due = (exp_q.size() > 0) && (exp_q[0].edge_no == cyc);
            chk("rec_en", rec_en, due);
            if (due) begin
                e = exp_q.pop_front();
                chk("rec_addr", rec_addr, e.addr);
                chk("rec_cacheline", rec_cacheline, e.data);
                last_addr = e.addr;
                last_line = e.data;
            end
        end
    end

    initial begin
        cacheline_t line_a, line_5, line_r;
        int         pool [8];
        rst       = 1'b0;
        req_ren   = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        line_a    = {8{32'hAAAA_AAAA}};
        line_5    = {8{32'h5555_5555}};
        for (int i = 0; i < 256; i++) model_valid[i] = 1'b0;

        idle(3);
        chk("reset_rec_en", rec_en, 0);
        chk("reset_rec_addr", rec_addr, 0);
        chk("reset_rec_cacheline", rec_cacheline, 0);
        chk("reset_req_ready", req_ready, 1);
        rst = 1'b1;
        idle(1);

        drive(0, 1, 32'h1040, line_a);
        drain();
        drive(1, 0, 32'h1040, '0);
        drain();
        drive(1, 0, 32'h1044, '0);
        drain();
        idle(3);
        chk("hold_rec_addr", rec_addr, 32'h1044);
        chk("hold_rec_cacheline", rec_cacheline, line_a);

        drive(1, 1, 32'h2000, line_5);
        drain();
        drive(1, 0, 32'h2000, '0);
        drain();

        drive(0, 1, 32'h3000, {8{32'h0123_4567}});
        drive(1, 0, 32'h1040, '0);
        drive(1, 0, 32'h2004, '0);
        drive(1, 0, 32'h3008, '0);
        drive(1, 0, 32'h1050, '0);
        chk("ready_low_when_full", req_ready, 0);
        drive(1, 0, 32'h2000, '0);
        drain();

        drive(1, 0, 32'h1040, '0);
        idle(2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        pend_pop.delete();
        server_free = 0;
        #1;
        chk("async_reset_rec_en", rec_en, 0);
        chk("async_reset_req_ready", req_ready, 1);
        idle(3);
        rst = 1'b1;
        idle(L + 4);
        drive(1, 0, 32'h1040, '0);
        drain();

        for (int i = 0; i < 8; i++) pool[i] = (i * 37 + 3) & 255;
        pool[0] = 8'h82;
        for (int i = 0; i < 20; i++) begin
            int    ln;
            bit    is_rd, both;
            pptr_t a;
            ln     = pool[$urandom_range(0, 7)];
            is_rd  = model_valid[ln] && ($urandom_range(0, 1) == 1);
            both   = !is_rd && ($urandom_range(0, 3) == 0);
            a      = ($urandom() & 32'hFFFF_E01F) | (pptr_t'(ln) << LINE_OFFSET_BITS);
            line_r = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
            drive(is_rd || both, !is_rd, a, line_r);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        chk("all_responses_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
